// File: rtl/uart_rx_core_if.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_core_if
//  Purpose  : Bundles the UART receiver's serial line, frame configuration
//             and parallel result/status outputs into one connection.
//  Ports    : RX_IN, PAR_EN, PAR_TYP, PRESCALE  -> receiver inputs
//             P_DATA, DATA_VLD, PAR_ERR, STP_ERR -> receiver outputs
//  Modports : master - line/config driver side (system / testbench)
//             slave  - the receiver itself
//  Revision : 1.0 - initial release
// ============================================================================
interface uart_rx_core_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  RX_IN;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic [5:0]            PRESCALE;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  DATA_VLD;
    logic                  PAR_ERR;
    logic                  STP_ERR;

    modport master (
        output RX_IN, PAR_EN, PAR_TYP, PRESCALE,
        input  P_DATA, DATA_VLD, PAR_ERR, STP_ERR
    );

    modport slave (
        input  RX_IN, PAR_EN, PAR_TYP, PRESCALE,
        output P_DATA, DATA_VLD, PAR_ERR, STP_ERR
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_core.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_core
//  Purpose  : UART receiver. Oversamples RX_IN at PRESCALE ticks per bit,
//             majority-votes three mid-bit samples and deframes
//             start / data (LSB first) / optional parity / stop bits.
//  Ports    : CLK  - oversampling clock
//             RST  - asynchronous, active-low reset
//             bus  - uart_rx_core_if.slave: RX_IN, PAR_EN, PAR_TYP, PRESCALE
//                    in; P_DATA, DATA_VLD, PAR_ERR, STP_ERR out (registered,
//                    status outputs are single-cycle pulses)
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx_core #(
    parameter int DATA_WIDTH = 8
) (
    input  wire logic         CLK,
    input  wire logic         RST,
    uart_rx_core_if.slave     bus
);

    localparam int c_BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_CHECK  = 3'd5
    } state_t;

    state_t                r_state;
    logic [5:0]            r_edge_cnt;
    logic [c_BIT_W-1:0]    r_bit_cnt;
    logic [5:0]            r_prescale;
    logic                  r_par_en;
    logic                  r_par_typ;
    logic                  r_smp0;
    logic                  r_smp1;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_par_flag;
    logic                  r_stp_flag;
    logic [DATA_WIDTH-1:0] r_p_data;
    logic                  r_data_vld;
    logic                  r_par_err;
    logic                  r_stp_err;

    logic [5:0] w_half;
    logic [5:0] w_smp_first;
    logic [5:0] w_decide_pt;
    logic [5:0] w_last;
    logic       w_decide;
    logic       w_at_last;
    logic       w_maj;
    logic       w_exp_par;
    logic       w_legal;

    // Sample points are derived from the latched ratio so that a change on
    // the PRESCALE input mid-frame cannot disturb the frame in flight.
    assign w_half      = r_prescale >> 1;
    assign w_smp_first = w_half - 6'd1;
    assign w_decide_pt = w_half + 6'd1;
    assign w_last      = r_prescale - 6'd1;
    assign w_decide    = (r_edge_cnt == w_decide_pt);
    assign w_at_last   = (r_edge_cnt == w_last);

    // Third sample is the live line value at the decision tick.
    assign w_maj = (r_smp0 & r_smp1) | (r_smp0 & bus.RX_IN) | (r_smp1 & bus.RX_IN);

    // r_shift holds the full data word by the time the parity bit arrives.
    assign w_exp_par = (^r_shift) ^ r_par_typ;

    assign w_legal = (bus.PRESCALE == 6'd8) || (bus.PRESCALE == 6'd16) ||
                     (bus.PRESCALE == 6'd32);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state    <= S_IDLE;
            r_edge_cnt <= '0;
            r_bit_cnt  <= '0;
            r_prescale <= 6'd8;
            r_par_en   <= 1'b0;
            r_par_typ  <= 1'b0;
            r_smp0     <= 1'b1;
            r_smp1     <= 1'b1;
            r_shift    <= '0;
            r_par_flag <= 1'b0;
            r_stp_flag <= 1'b0;
            r_p_data   <= '0;
            r_data_vld <= 1'b0;
            r_par_err  <= 1'b0;
            r_stp_err  <= 1'b0;
        end else begin
            r_data_vld <= 1'b0;
            r_par_err  <= 1'b0;
            r_stp_err  <= 1'b0;

            if (r_edge_cnt == w_smp_first) r_smp0 <= bus.RX_IN;
            if (r_edge_cnt == w_half)      r_smp1 <= bus.RX_IN;

            case (r_state)
                S_IDLE: begin
                    r_edge_cnt <= '0;
                    if (!bus.RX_IN && w_legal) begin
                        r_state    <= S_START;
                        r_prescale <= bus.PRESCALE;
                        r_par_en   <= bus.PAR_EN;
                        r_par_typ  <= bus.PAR_TYP;
                    end
                end

                S_START: begin
                    if (w_decide && w_maj) begin
                        // Start pulse too short to be a real start bit.
                        r_state    <= S_IDLE;
                        r_edge_cnt <= '0;
                    end else if (w_at_last) begin
                        r_state    <= S_DATA;
                        r_edge_cnt <= '0;
                        r_bit_cnt  <= '0;
                    end else begin
                        r_edge_cnt <= r_edge_cnt + 6'd1;
                    end
                end

                S_DATA: begin
                    if (w_decide) r_shift <= {w_maj, r_shift[DATA_WIDTH-1:1]};
                    if (w_at_last) begin
                        r_edge_cnt <= '0;
                        if (r_bit_cnt == c_BIT_LAST) begin
                            r_bit_cnt <= '0;
                            r_state   <= r_par_en ? S_PARITY : S_STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end else begin
                        r_edge_cnt <= r_edge_cnt + 6'd1;
                    end
                end

                S_PARITY: begin
                    if (w_decide && (w_maj != w_exp_par)) r_par_flag <= 1'b1;
                    if (w_at_last) begin
                        r_state    <= S_STOP;
                        r_edge_cnt <= '0;
                    end else begin
                        r_edge_cnt <= r_edge_cnt + 6'd1;
                    end
                end

                S_STOP: begin
                    // Leave right after the mid-bit decision so a start edge
                    // immediately following the stop bit is not missed.
                    if (w_decide) begin
                        if (!w_maj) r_stp_flag <= 1'b1;
                        r_state    <= S_CHECK;
                        r_edge_cnt <= '0;
                    end else begin
                        r_edge_cnt <= r_edge_cnt + 6'd1;
                    end
                end

                S_CHECK: begin
                    if (!r_par_flag && !r_stp_flag) begin
                        r_data_vld <= 1'b1;
                        r_p_data   <= r_shift;
                    end else begin
                        r_par_err <= r_par_flag;
                        r_stp_err <= r_stp_flag;
                    end
                    r_par_flag <= 1'b0;
                    r_stp_flag <= 1'b0;
                    r_edge_cnt <= '0;
                    if (!bus.RX_IN && w_legal) begin
                        r_state    <= S_START;
                        r_prescale <= bus.PRESCALE;
                        r_par_en   <= bus.PAR_EN;
                        r_par_typ  <= bus.PAR_TYP;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_state    <= S_IDLE;
                    r_edge_cnt <= '0;
                end
            endcase
        end
    end

    assign bus.P_DATA   = r_p_data;
    assign bus.DATA_VLD = r_data_vld;
    assign bus.PAR_ERR  = r_par_err;
    assign bus.STP_ERR  = r_stp_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_core.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx_core
//  Purpose  : Directed self-checking bench for uart_rx_core.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_core;

    logic CLK = 1'b0;
    logic RST = 1'b0;

    int total = 0;
    int bad   = 0;

    // Pulse counters and captured data, written only by the monitor.
    int        vld_cnt = 0;
    int        par_cnt = 0;
    int        stp_cnt = 0;
    logic [7:0] got [0:7];

    uart_rx_core_if #(.DATA_WIDTH(8)) bus ();

    uart_rx_core #(.DATA_WIDTH(8)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (bus.DATA_VLD === 1'b1) begin
            got[vld_cnt % 8] = bus.P_DATA;
            vld_cnt = vld_cnt + 1;
        end
        if (bus.PAR_ERR === 1'b1) par_cnt = par_cnt + 1;
        if (bus.STP_ERR === 1'b1) stp_cnt = stp_cnt + 1;
    end

    task automatic idle(input int n);
        bus.RX_IN = 1'b1;
        repeat (n) @(negedge CLK);
    endtask

    task automatic drive_bit(input logic b, input int p, input bit glitch);
        for (int t = 0; t < p; t++) begin
            bus.RX_IN = (glitch && t == p / 2) ? ~b : b;
            @(negedge CLK);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input int p, input bit pen,
                              input logic pbit, input logic sbit, input bit glitch);
        drive_bit(1'b0, p, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i], p, glitch);
        if (pen) drive_bit(pbit, p, 1'b0);
        drive_bit(sbit, p, 1'b0);
    endtask

    task automatic config_line(input int p, input bit pen, input bit ptyp);
        bus.PRESCALE = 6'(p);
        bus.PAR_EN   = pen;
        bus.PAR_TYP  = ptyp;
    endtask

    task automatic test_reset;
        bus.RX_IN = 1'b1;
        config_line(8, 1'b0, 1'b0);
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        total++; if (bus.P_DATA !== 8'h00) begin bad++; $display("FAIL reset_pdata: got %h want 00", bus.P_DATA); end
        total++; if (bus.DATA_VLD !== 1'b0) begin bad++; $display("FAIL reset_vld: got %b want 0", bus.DATA_VLD); end
        total++; if (bus.PAR_ERR !== 1'b0) begin bad++; $display("FAIL reset_par: got %b want 0", bus.PAR_ERR); end
        total++; if (bus.STP_ERR !== 1'b0) begin bad++; $display("FAIL reset_stp: got %b want 0", bus.STP_ERR); end
        RST = 1'b1;
        idle(4);
    endtask

    task automatic test_basic_p8;
        int v0, p0, s0;
        v0 = vld_cnt; p0 = par_cnt; s0 = stp_cnt;
        config_line(8, 1'b0, 1'b0);
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(16);
        total++; if (vld_cnt - v0 !== 1) begin bad++; $display("FAIL p8_vld_count: got %0d want 1", vld_cnt - v0); end
        total++; if (got[v0 % 8] !== 8'hA5) begin bad++; $display("FAIL p8_data: got %h want a5", got[v0 % 8]); end
        total++; if (par_cnt - p0 !== 0) begin bad++; $display("FAIL p8_par: got %0d want 0", par_cnt - p0); end
        total++; if (stp_cnt - s0 !== 0) begin bad++; $display("FAIL p8_stp: got %0d want 0", stp_cnt - s0); end
    endtask

    task automatic test_parity_p16;
        int v0, p0;
        v0 = vld_cnt; p0 = par_cnt;
        config_line(16, 1'b1, 1'b0);
        // 0x3C has four ones: even parity bit is 0.
        send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(32);
        total++; if (vld_cnt - v0 !== 1) begin bad++; $display("FAIL par_good_vld: got %0d want 1", vld_cnt - v0); end
        total++; if (bus.P_DATA !== 8'h3C) begin bad++; $display("FAIL par_good_data: got %h want 3c", bus.P_DATA); end
        v0 = vld_cnt;
        send_frame(8'h3C, 16, 1'b1, 1'b1, 1'b1, 1'b0);
        idle(32);
        total++; if (par_cnt - p0 !== 1) begin bad++; $display("FAIL par_bad_err: got %0d want 1", par_cnt - p0); end
        total++; if (vld_cnt - v0 !== 0) begin bad++; $display("FAIL par_bad_vld: got %0d want 0", vld_cnt - v0); end
        total++; if (bus.P_DATA !== 8'h3C) begin bad++; $display("FAIL par_bad_hold: got %h want 3c", bus.P_DATA); end
    endtask

    task automatic test_stop_err_p32;
        int v0, p0, s0;
        v0 = vld_cnt; p0 = par_cnt; s0 = stp_cnt;
        config_line(32, 1'b1, 1'b1);
        // 0x01 has one one: odd parity bit is 0.
        send_frame(8'h01, 32, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(64);
        total++; if (stp_cnt - s0 !== 1) begin bad++; $display("FAIL stp_err: got %0d want 1", stp_cnt - s0); end
        total++; if (vld_cnt - v0 !== 0) begin bad++; $display("FAIL stp_vld: got %0d want 0", vld_cnt - v0); end
        total++; if (par_cnt - p0 !== 0) begin bad++; $display("FAIL stp_par: got %0d want 0", par_cnt - p0); end
    endtask

    task automatic test_start_glitch;
        int v0, p0, s0;
        v0 = vld_cnt; p0 = par_cnt; s0 = stp_cnt;
        config_line(16, 1'b0, 1'b0);
        bus.RX_IN = 1'b0;
        repeat (2) @(negedge CLK);
        idle(40);
        total++; if ((vld_cnt - v0) + (par_cnt - p0) + (stp_cnt - s0) !== 0) begin
            bad++; $display("FAIL start_glitch_pulses: got %0d want 0", (vld_cnt - v0) + (par_cnt - p0) + (stp_cnt - s0));
        end
        send_frame(8'h55, 16, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(32);
        total++; if (vld_cnt - v0 !== 1) begin bad++; $display("FAIL after_glitch_vld: got %0d want 1", vld_cnt - v0); end
        total++; if (got[v0 % 8] !== 8'h55) begin bad++; $display("FAIL after_glitch_data: got %h want 55", got[v0 % 8]); end
    endtask

    task automatic test_majority;
        int v0;
        v0 = vld_cnt;
        config_line(16, 1'b0, 1'b0);
        send_frame(8'hF0, 16, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(32);
        total++; if (vld_cnt - v0 !== 1) begin bad++; $display("FAIL majority_vld: got %0d want 1", vld_cnt - v0); end
        total++; if (got[v0 % 8] !== 8'hF0) begin bad++; $display("FAIL majority_data: got %h want f0", got[v0 % 8]); end
    endtask

    task automatic test_back_to_back;
        int v0, s0;
        v0 = vld_cnt; s0 = stp_cnt;
        config_line(8, 1'b0, 1'b0);
        send_frame(8'h12, 8, 1'b0, 1'b0, 1'b1, 1'b0);
        send_frame(8'h34, 8, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(16);
        total++; if (vld_cnt - v0 !== 2) begin bad++; $display("FAIL b2b_count: got %0d want 2", vld_cnt - v0); end
        total++; if (got[v0 % 8] !== 8'h12) begin bad++; $display("FAIL b2b_first: got %h want 12", got[v0 % 8]); end
        total++; if (got[(v0 + 1) % 8] !== 8'h34) begin bad++; $display("FAIL b2b_second: got %h want 34", got[(v0 + 1) % 8]); end
        total++; if (stp_cnt - s0 !== 0) begin bad++; $display("FAIL b2b_stp: got %0d want 0", stp_cnt - s0); end
    endtask

    task automatic test_illegal_prescale;
        int v0, p0, s0;
        v0 = vld_cnt; p0 = par_cnt; s0 = stp_cnt;
        config_line(12, 1'b0, 1'b0);
        send_frame(8'hA5, 12, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(24);
        total++; if ((vld_cnt - v0) + (par_cnt - p0) + (stp_cnt - s0) !== 0) begin
            bad++; $display("FAIL illegal_prescale_pulses: got %0d want 0", (vld_cnt - v0) + (par_cnt - p0) + (stp_cnt - s0));
        end
    endtask

    task automatic test_break;
        int v0, s0;
        v0 = vld_cnt; s0 = stp_cnt;
        config_line(8, 1'b0, 1'b0);
        bus.RX_IN = 1'b0;
        repeat (250) @(negedge CLK);
        total++; if (stp_cnt - s0 < 2) begin bad++; $display("FAIL break_stp: got %0d want >=2", stp_cnt - s0); end
        total++; if (vld_cnt - v0 !== 0) begin bad++; $display("FAIL break_vld: got %0d want 0", vld_cnt - v0); end
        bus.RX_IN = 1'b1;
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        idle(4);
    endtask

    task automatic test_reset_mid_frame;
        int v0, p0, s0;
        config_line(8, 1'b0, 1'b0);
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(16);
        total++; if (bus.P_DATA !== 8'h5A) begin bad++; $display("FAIL pre_reset_data: got %h want 5a", bus.P_DATA); end
        v0 = vld_cnt; p0 = par_cnt; s0 = stp_cnt;
        drive_bit(1'b0, 8, 1'b0);
        drive_bit(1'b1, 8, 1'b0);
        drive_bit(1'b0, 8, 1'b0);
        RST = 1'b0;
        #1;
        total++; if (bus.P_DATA !== 8'h00) begin bad++; $display("FAIL midreset_data: got %h want 00", bus.P_DATA); end
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        idle(120);
        total++; if ((vld_cnt - v0) + (par_cnt - p0) + (stp_cnt - s0) !== 0) begin
            bad++; $display("FAIL midreset_pulses: got %0d want 0", (vld_cnt - v0) + (par_cnt - p0) + (stp_cnt - s0));
        end
        v0 = vld_cnt;
        send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(16);
        total++; if (vld_cnt - v0 !== 1) begin bad++; $display("FAIL post_reset_vld: got %0d want 1", vld_cnt - v0); end
        total++; if (got[v0 % 8] !== 8'hC3) begin bad++; $display("FAIL post_reset_data: got %h want c3", got[v0 % 8]); end
    endtask

    initial begin
        bus.RX_IN    = 1'b1;
        bus.PAR_EN   = 1'b0;
        bus.PAR_TYP  = 1'b0;
        bus.PRESCALE = 6'd8;
        test_reset();
        test_basic_p8();
        test_parity_p16();
        test_stop_err_p32();
        test_start_glitch();
        test_majority();
        test_back_to_back();
        test_illegal_prescale();
        test_break();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
